// File: rtl/sbus_sram_bridge_if.sv
// Signal bundle between an sbus master, the sbus-to-SRAM bridge and an SRAM-like slave.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface sbus_sram_bridge_if;
  logic        s_en;
  logic        s_we;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_data_w;
  logic [31:0] s_data_r;
  logic        s_stall;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  modport slave (
    input  s_en, s_we, s_size, s_addr, s_data_w, m_addr_ok, m_data_ok, m_rdata,
    output s_data_r, s_stall, m_req, m_wr, m_size, m_addr, m_wdata
  );

  modport master (
    output s_en, s_we, s_size, s_addr, s_data_w, m_addr_ok, m_data_ok, m_rdata,
    input  s_data_r, s_stall, m_req, m_wr, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/sbus_sram_bridge.sv
// Bridges a stalling sbus master onto an SRAM-like addr_ok/data_ok slave, one transaction
// at a time: IDLE latches the request, REQ handshakes the address, WAIT collects the data.
module sbus_sram_bridge #(
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
  input logic           clk,
  input logic           resetn,
  sbus_sram_bridge_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.s_en) begin
          we_d    = bus.s_we;
          // Size 3 is not a legal SRAM size; fold it onto word.
          size_d  = (bus.s_size == 2'd3) ? 2'd2 : bus.s_size;
          addr_d  = bus.s_addr & PHYS_MASK;
          wdata_d = bus.s_data_w;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.m_addr_ok) state_d = StWait;
      end
      StWait: begin
        if (bus.m_data_ok) begin
          state_d = StDone;
          if (!we_q) rdata_d = bus.m_rdata;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields come straight from the latched copy, so they stay stable while m_req waits.
  assign bus.m_req    = (state_q == StReq);
  assign bus.m_wr     = we_q;
  assign bus.m_size   = size_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.s_data_r = rdata_q;
  assign bus.s_stall  = bus.s_en & (state_q != StDone);

endmodule
